// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } pipe_state_e;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/pipeline_ctrl_forward_unit.sv
// EX operand bypass select; the youngest producer (EX/MEM) wins over MEM/WB.
module forward_unit
#(
    parameter int REG_AW = pipe_pkg::REG_AW
)(
    input  logic [REG_AW-1:0] IDEX_rs1_i,
    input  logic [REG_AW-1:0] IDEX_rs2_i,
    input  logic [REG_AW-1:0] EXMEM_rd_i,
    input  logic              EXMEM_RegWrite_i,
    input  logic [REG_AW-1:0] MEMWB_rd_i,
    input  logic              MEMWB_RegWrite_i,
    output logic [1:0]        ForwardA_o,
    output logic [1:0]        ForwardB_o
);
    import pipe_pkg::*;

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        logic [1:0] sel;
        sel = FWD_REG;
        if (EXMEM_RegWrite_i && (EXMEM_rd_i != '0) && (EXMEM_rd_i == rs))
            sel = FWD_MEM;
        else if (MEMWB_RegWrite_i && (MEMWB_rd_i != '0) && (MEMWB_rd_i == rs))
            sel = FWD_WB;
        return sel;
    endfunction

    assign ForwardA_o = fwd_sel(IDEX_rs1_i);
    assign ForwardB_o = fwd_sel(IDEX_rs2_i);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush/forward controller with data-memory wait FSM.
// Build option: define FORWARDING_EN to enable EX operand bypassing.
//
// state       | meaning
// ------------+------------------------------------------------------
// ST_RUN      | normal flow; unacked access moves to ST_MEM_WAIT
// ST_MEM_WAIT | waiting for dmem_ack_i, wait counter running
// ST_ERROR    | memory timeout; pipeline frozen until reset
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int REG_AW      = pipe_pkg::REG_AW
)(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [REG_AW-1:0] IFID_rs1_i,
    input  logic [REG_AW-1:0] IFID_rs2_i,
    input  logic [REG_AW-1:0] IDEX_rs1_i,
    input  logic [REG_AW-1:0] IDEX_rs2_i,
    input  logic [REG_AW-1:0] IDEX_rd_i,
    input  logic              IDEX_MemRead_i,
    input  logic              IDEX_RegWrite_i,
    input  logic [REG_AW-1:0] EXMEM_rd_i,
    input  logic              EXMEM_RegWrite_i,
    input  logic              EXMEM_MemRead_i,
    input  logic              EXMEM_MemWrite_i,
    input  logic [REG_AW-1:0] MEMWB_rd_i,
    input  logic              MEMWB_RegWrite_i,
    input  logic              Branch_taken_i,
    input  logic              dmem_ack_i,
    output logic              dmem_req_o,
    output logic              PC_stall_o,
    output logic              IFID_stall_o,
    output logic              IDEX_stall_o,
    output logic              EXMEM_stall_o,
    output logic              IFID_flush_o,
    output logic              IDEX_bubble_o,
    output logic              MEMWB_bubble_o,
    output logic [1:0]        ForwardA_o,
    output logic [1:0]        ForwardB_o,
    output logic              err_o
);
    localparam int              CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    pipe_state_e      state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic             mem_access, mem_stall, load_use, data_hazard;
    logic [1:0]       fwd_a, fwd_b;

    assign mem_access = EXMEM_MemRead_i | EXMEM_MemWrite_i;
    assign load_use   = IDEX_MemRead_i && (IDEX_rd_i != '0) &&
                        ((IDEX_rd_i == IFID_rs1_i) || (IDEX_rd_i == IFID_rs2_i));

`ifdef FORWARDING_EN
    logic unused_fwd_in;
    assign unused_fwd_in = IDEX_RegWrite_i;
    assign data_hazard   = load_use;

    forward_unit #(.REG_AW(REG_AW)) u_forward_unit (
        .IDEX_rs1_i       (IDEX_rs1_i),
        .IDEX_rs2_i       (IDEX_rs2_i),
        .EXMEM_rd_i       (EXMEM_rd_i),
        .EXMEM_RegWrite_i (EXMEM_RegWrite_i),
        .MEMWB_rd_i       (MEMWB_rd_i),
        .MEMWB_RegWrite_i (MEMWB_RegWrite_i),
        .ForwardA_o       (fwd_a),
        .ForwardB_o       (fwd_b)
    );
`else
    // Without bypassing, any in-flight producer of an ID source must drain first.
    function automatic logic raw_dep(input logic [REG_AW-1:0] rs);
        return (rs != '0) &&
               ((IDEX_RegWrite_i && (IDEX_rd_i == rs)) ||
                (EXMEM_RegWrite_i && (EXMEM_rd_i == rs)));
    endfunction

    logic unused_fwd_in;
    assign unused_fwd_in = ^{IDEX_rs1_i, IDEX_rs2_i, MEMWB_rd_i, MEMWB_RegWrite_i};
    assign data_hazard   = load_use | raw_dep(IFID_rs1_i) | raw_dep(IFID_rs2_i);
    assign fwd_a         = FWD_REG;
    assign fwd_b         = FWD_REG;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        dmem_req_o     = 1'b0;
        PC_stall_o     = 1'b0;
        IFID_stall_o   = 1'b0;
        IDEX_stall_o   = 1'b0;
        EXMEM_stall_o  = 1'b0;
        IFID_flush_o   = 1'b0;
        IDEX_bubble_o  = 1'b0;
        MEMWB_bubble_o = 1'b0;
        ForwardA_o     = FWD_REG;
        ForwardB_o     = FWD_REG;
        err_o          = 1'b0;
        mem_stall      = 1'b0;

        case (state)
            ST_RUN: begin
                if (mem_access && !dmem_ack_i) begin
                    state_nxt    = ST_MEM_WAIT;
                    wait_cnt_nxt = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ack_i) begin
                    state_nxt = ST_RUN;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                    if (wait_cnt == CNT_LAST)
                        state_nxt = ST_ERROR;
                end
            end
            ST_ERROR: ;
            default:  state_nxt = ST_RUN;
        endcase

        // Outputs are forced low while reset is held, independent of the clock.
        if (rst_n_i) begin
            err_o          = (state == ST_ERROR);
            mem_stall      = err_o | (mem_access & ~dmem_ack_i);
            dmem_req_o     = mem_access & ~err_o;
            PC_stall_o     = mem_stall | data_hazard;
            IFID_stall_o   = mem_stall | data_hazard;
            IDEX_stall_o   = mem_stall;
            EXMEM_stall_o  = mem_stall;
            MEMWB_bubble_o = mem_stall;
            IDEX_bubble_o  = ~mem_stall & data_hazard;
            IFID_flush_o   = ~mem_stall & ~data_hazard & Branch_taken_i;
            ForwardA_o     = fwd_a;
            ForwardB_o     = fwd_b;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic
// checked against a timestamp-based reference model. Honors FORWARDING_EN.
module tb_pipeline_ctrl;
    localparam int TMO = 4;
    localparam int AW  = 5;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic [AW-1:0] IFID_rs1_i, IFID_rs2_i, IDEX_rs1_i, IDEX_rs2_i, IDEX_rd_i;
    logic          IDEX_MemRead_i, IDEX_RegWrite_i;
    logic [AW-1:0] EXMEM_rd_i, MEMWB_rd_i;
    logic          EXMEM_RegWrite_i, EXMEM_MemRead_i, EXMEM_MemWrite_i, MEMWB_RegWrite_i;
    logic          Branch_taken_i, dmem_ack_i;
    logic          dmem_req_o, PC_stall_o, IFID_stall_o, IDEX_stall_o, EXMEM_stall_o;
    logic          IFID_flush_o, IDEX_bubble_o, MEMWB_bubble_o, err_o;
    logic [1:0]    ForwardA_o, ForwardB_o;

    int total = 0;
    int bad   = 0;

    // Reference model: an unacked access started at cycle m_start times out once
    // TMO further cycles have elapsed without an ack.
    bit m_err, m_wait;
    int m_start, cyc;

    always #5 clk_i = ~clk_i;

    pipeline_ctrl #(.MEM_TIMEOUT(TMO), .REG_AW(AW)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .IFID_rs1_i(IFID_rs1_i), .IFID_rs2_i(IFID_rs2_i),
        .IDEX_rs1_i(IDEX_rs1_i), .IDEX_rs2_i(IDEX_rs2_i), .IDEX_rd_i(IDEX_rd_i),
        .IDEX_MemRead_i(IDEX_MemRead_i), .IDEX_RegWrite_i(IDEX_RegWrite_i),
        .EXMEM_rd_i(EXMEM_rd_i), .EXMEM_RegWrite_i(EXMEM_RegWrite_i),
        .EXMEM_MemRead_i(EXMEM_MemRead_i), .EXMEM_MemWrite_i(EXMEM_MemWrite_i),
        .MEMWB_rd_i(MEMWB_rd_i), .MEMWB_RegWrite_i(MEMWB_RegWrite_i),
        .Branch_taken_i(Branch_taken_i), .dmem_ack_i(dmem_ack_i),
        .dmem_req_o(dmem_req_o), .PC_stall_o(PC_stall_o), .IFID_stall_o(IFID_stall_o),
        .IDEX_stall_o(IDEX_stall_o), .EXMEM_stall_o(EXMEM_stall_o),
        .IFID_flush_o(IFID_flush_o), .IDEX_bubble_o(IDEX_bubble_o),
        .MEMWB_bubble_o(MEMWB_bubble_o), .ForwardA_o(ForwardA_o),
        .ForwardB_o(ForwardB_o), .err_o(err_o)
    );

    function automatic logic [1:0] m_fwd(input logic [AW-1:0] rs);
`ifdef FORWARDING_EN
        if (EXMEM_RegWrite_i && EXMEM_rd_i != 0 && EXMEM_rd_i == rs) return 2'b10;
        if (MEMWB_RegWrite_i && MEMWB_rd_i != 0 && MEMWB_rd_i == rs) return 2'b01;
`endif
        return 2'b00;
    endfunction

    function automatic logic m_dep(input logic [AW-1:0] rs);
`ifdef FORWARDING_EN
        return 1'b0;
`else
        return rs != 0 && ((IDEX_RegWrite_i && IDEX_rd_i == rs) ||
                           (EXMEM_RegWrite_i && EXMEM_rd_i == rs));
`endif
    endfunction

    // {req, pc, ifid, idex, exmem, flush, idex_bub, memwb_bub, fwdA, fwdB, err}
    function automatic logic [12:0] exp_vec();
        logic acc, ms, hz, lu;
        if (rst_n_i !== 1'b1) return '0;
        acc = EXMEM_MemRead_i | EXMEM_MemWrite_i;
        ms  = m_err | (acc & ~dmem_ack_i);
        lu  = IDEX_MemRead_i && IDEX_rd_i != 0 &&
              (IDEX_rd_i == IFID_rs1_i || IDEX_rd_i == IFID_rs2_i);
        hz  = lu | m_dep(IFID_rs1_i) | m_dep(IFID_rs2_i);
        return {acc & ~m_err, ms | hz, ms | hz, ms, ms, ~ms & ~hz & Branch_taken_i,
                ~ms & hz, ms, m_fwd(IDEX_rs1_i), m_fwd(IDEX_rs2_i), m_err};
    endfunction

    function automatic logic [12:0] obs_vec();
        return {dmem_req_o, PC_stall_o, IFID_stall_o, IDEX_stall_o, EXMEM_stall_o,
                IFID_flush_o, IDEX_bubble_o, MEMWB_bubble_o, ForwardA_o, ForwardB_o, err_o};
    endfunction

    task automatic check_model(input string tag);
        logic [12:0] o, e;
        o = obs_vec();
        e = exp_vec();
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: outputs got %b expected %b", tag, o, e);
        end
    endtask

    task automatic chk(input string tag, input logic [1:0] o, input logic [1:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: got %b expected %b", tag, o, e);
        end
    endtask

    task automatic advance();
        @(posedge clk_i);
        if (rst_n_i === 1'b1 && !m_err) begin
            if (m_wait) begin
                if (dmem_ack_i) m_wait = 0;
                else if (cyc - m_start == TMO) m_err = 1;
            end else if ((EXMEM_MemRead_i | EXMEM_MemWrite_i) && !dmem_ack_i) begin
                m_wait  = 1;
                m_start = cyc;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic step(input string tag);
        #2;
        check_model(tag);
        advance();
    endtask

    task automatic do_reset(input string tag);
        rst_n_i = 1'b0;
        m_err   = 0;
        m_wait  = 0;
        #1;
        check_model(tag);
        chk({tag, "_err"}, {1'b0, err_o}, 2'b00);
        @(posedge clk_i);
        #3;
        rst_n_i = 1'b1;
    endtask

    task automatic clear_inputs();
        {IFID_rs1_i, IFID_rs2_i, IDEX_rs1_i, IDEX_rs2_i, IDEX_rd_i} = '0;
        {IDEX_MemRead_i, IDEX_RegWrite_i, EXMEM_RegWrite_i, MEMWB_RegWrite_i} = '0;
        {EXMEM_rd_i, MEMWB_rd_i} = '0;
        {EXMEM_MemRead_i, EXMEM_MemWrite_i, Branch_taken_i} = '0;
        dmem_ack_i = 1'b1;
    endtask

    initial begin
        m_err = 0; m_wait = 0; m_start = 0; cyc = 0;
        clear_inputs();
        rst_n_i = 1'b0;
        IDEX_rs1_i = 5'd3; EXMEM_rd_i = 5'd3; EXMEM_RegWrite_i = 1'b1; EXMEM_MemRead_i = 1'b1;
        #3;
        check_model("reset_state");
        chk("reset_fwdA", ForwardA_o, 2'b00);
        chk("reset_req", {1'b0, dmem_req_o}, 2'b00);
        clear_inputs();
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;

        // Load-use: stall one cycle, then released once the load moves on
        IDEX_MemRead_i = 1; IDEX_RegWrite_i = 1; IDEX_rd_i = 5'd5; IFID_rs1_i = 5'd5;
        #2;
        chk("lu_pc", {1'b0, PC_stall_o}, 2'b01);
        chk("lu_ifid", {1'b0, IFID_stall_o}, 2'b01);
        chk("lu_bubble", {1'b0, IDEX_bubble_o}, 2'b01);
        check_model("lu_model");
        advance();
        IDEX_MemRead_i = 0; IDEX_RegWrite_i = 0; IDEX_rd_i = 0;
        #2;
        chk("lu_after", {PC_stall_o, IDEX_bubble_o}, 2'b00);
        advance();

        // Memory wait: ack low 3 cycles then high
        clear_inputs();
        EXMEM_MemRead_i = 1;
        for (int i = 0; i < 4; i++) begin
            dmem_ack_i = (i == 3);
            #2;
            chk("mw_req", {1'b0, dmem_req_o}, 2'b01);
            chk("mw_exmem_stall", {1'b0, EXMEM_stall_o}, {1'b0, i != 3});
            check_model("mw_model");
            advance();
        end
        EXMEM_MemRead_i = 0;
        step("mw_idle");

        // Branch under stall: flush suppressed until the ack releases the stall
        EXMEM_MemWrite_i = 1; dmem_ack_i = 0; Branch_taken_i = 1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) dmem_ack_i = 1;
            #2;
            chk("br_flush", {1'b0, IFID_flush_o}, {1'b0, i == 2});
            check_model("br_model");
            advance();
        end
        clear_inputs();
        step("br_idle");

        // Timeout: 5 stall cycles then sticky error
        EXMEM_MemRead_i = 1; dmem_ack_i = 0;
        for (int i = 0; i < TMO + 1; i++) begin
            #2;
            chk("to_noerr", {err_o, EXMEM_stall_o}, 2'b01);
            check_model("to_model");
            advance();
        end
        #2;
        chk("to_err", {err_o, dmem_req_o}, 2'b10);
        chk("to_stall", {PC_stall_o, MEMWB_bubble_o}, 2'b11);
        check_model("to_model_err");
        advance();
        EXMEM_MemRead_i = 0; dmem_ack_i = 1;
        #2;
        chk("to_sticky", {err_o, IDEX_stall_o}, 2'b11);
        advance();
        do_reset("to_reset");
        clear_inputs();
        step("to_after_reset");

        // Reset mid-wait abandons the access
        EXMEM_MemWrite_i = 1; dmem_ack_i = 0;
        step("rw_0");
        step("rw_1");
        #2;
        do_reset("rw_reset");
        clear_inputs();
        #2;
        chk("rw_no_req", {dmem_req_o, EXMEM_stall_o}, 2'b00);
        advance();

        // Forward selection / non-forwarding RAW stall
        IDEX_rs1_i = 5'd3; EXMEM_rd_i = 5'd3; EXMEM_RegWrite_i = 1;
        MEMWB_rd_i = 5'd3; MEMWB_RegWrite_i = 1; IFID_rs1_i = 5'd3;
        #2;
`ifdef FORWARDING_EN
        chk("fwd_mem", ForwardA_o, 2'b10);
        chk("fwd_nostall", {1'b0, PC_stall_o}, 2'b00);
`else
        chk("fwd_off", ForwardA_o, 2'b00);
        chk("raw_stall", {PC_stall_o, IDEX_bubble_o}, 2'b11);
`endif
        check_model("fwd_model_a");
        advance();
        EXMEM_rd_i = 5'd0;
        #2;
`ifdef FORWARDING_EN
        chk("fwd_wb", ForwardA_o, 2'b01);
`else
        chk("fwd_off_wb", ForwardA_o, 2'b00);
`endif
        check_model("fwd_model_b");
        advance();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            IFID_rs1_i       = 5'($urandom_range(3));
            IFID_rs2_i       = 5'($urandom_range(3));
            IDEX_rs1_i       = 5'($urandom_range(3));
            IDEX_rs2_i       = 5'($urandom_range(3));
            IDEX_rd_i        = 5'($urandom_range(3));
            EXMEM_rd_i       = 5'($urandom_range(3));
            MEMWB_rd_i       = 5'($urandom_range(3));
            IDEX_MemRead_i   = ($urandom_range(3) == 0);
            IDEX_RegWrite_i  = 1'($urandom_range(1));
            EXMEM_RegWrite_i = 1'($urandom_range(1));
            MEMWB_RegWrite_i = 1'($urandom_range(1));
            EXMEM_MemRead_i  = ($urandom_range(2) == 0);
            EXMEM_MemWrite_i = ($urandom_range(3) == 0);
            Branch_taken_i   = ($urandom_range(3) == 0);
            dmem_ack_i       = ($urandom_range(9) < 6);
            if ($urandom_range(59) == 0) begin
                #1;
                do_reset("rand_reset");
            end else begin
                step("rand");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
